// File: rtl/bcd_convert_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : bcd_convert_scheduler
// Purpose  : Shared shift-and-add-3 binary-to-BCD engine with round-robin
//            arbitration. Optional macro BCD_RANGE_CHECK_EN clamps to 99.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_convert_scheduler #(
    parameter int N_CH = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   req,
    input  logic [8*N_CH-1:0] bin_flat,
    output logic [N_CH-1:0]   ack,
    output logic              busy,
    output logic [11:0]       bcd_out,
    output logic [1:0]        bcd_ch,
    output logic              bcd_valid,
    output logic              ovf
);

    localparam logic [1:0] C_IDLE  = 2'd0;
    localparam logic [1:0] C_SHIFT = 2'd1;
    localparam logic [1:0] C_DONE  = 2'd2;

    logic [1:0]      r_state;
    logic [19:0]     r_work;
    logic [2:0]      r_cnt;
    logic [1:0]      r_ptr;
    logic [1:0]      r_cur_ch;
    logic            r_clamp;

    logic            w_found;
    logic [1:0]      w_idx;
    logic [1:0]      w_cand;
    logic [N_CH-1:0] w_onehot;
    logic [7:0]      w_raw;
    logic [7:0]      w_operand;
    logic            w_clamp;
    logic [1:0]      w_next_ptr;

    // One add-3 correction pass followed by a left shift of {bcd, bin}.
    function automatic logic [19:0] shift_step(input logic [19:0] w);
        logic [19:0] a;
        a = w;
        if (a[19:16] >= 4'd5) a[19:16] = a[19:16] + 4'd3;
        if (a[15:12] >= 4'd5) a[15:12] = a[15:12] + 4'd3;
        if (a[11:8]  >= 4'd5) a[11:8]  = a[11:8]  + 4'd3;
        return {a[18:0], 1'b0};
    endfunction

    // Search starts at the pointer and wraps, so the last winner goes last.
    always_comb begin
        w_found  = 1'b0;
        w_idx    = 2'd0;
        w_cand   = 2'd0;
        w_onehot = '0;
        w_raw    = 8'd0;
        for (int i = 0; i < N_CH; i++) begin
            w_cand = 2'((int'(r_ptr) + i) % N_CH);
            for (int k = 0; k < N_CH; k++) begin
                if (!w_found && (w_cand == 2'(k)) && req[k]) begin
                    w_found = 1'b1;
                    w_idx   = w_cand;
                end
            end
        end
        for (int k = 0; k < N_CH; k++) begin
            if (w_idx == 2'(k)) begin
                w_raw       = bin_flat[8*k +: 8];
                w_onehot[k] = w_found;
            end
        end
    end

`ifdef BCD_RANGE_CHECK_EN
    assign w_clamp   = (w_raw > 8'd99);
    assign w_operand = w_clamp ? 8'd99 : w_raw;
`else
    assign w_clamp   = 1'b0;
    assign w_operand = w_raw;
`endif

    assign w_next_ptr = (w_idx == 2'(N_CH - 1)) ? 2'd0 : w_idx + 2'd1;
    assign busy       = (r_state != C_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= C_IDLE;
            r_work    <= 20'd0;
            r_cnt     <= 3'd0;
            r_ptr     <= 2'd0;
            r_cur_ch  <= 2'd0;
            r_clamp   <= 1'b0;
            ack       <= '0;
            bcd_out   <= 12'h000;
            bcd_ch    <= 2'd0;
            bcd_valid <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            ack       <= '0;
            bcd_valid <= 1'b0;
            case (r_state)
                C_IDLE: begin
                    if (w_found) begin
                        r_work   <= {12'h000, w_operand};
                        r_cur_ch <= w_idx;
                        r_clamp  <= w_clamp;
                        r_cnt    <= 3'd0;
                        r_ptr    <= w_next_ptr;
                        ack      <= w_onehot;
                        r_state  <= C_SHIFT;
                    end
                end
                C_SHIFT: begin
                    r_work <= shift_step(r_work);
                    r_cnt  <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) r_state <= C_DONE;
                end
                C_DONE: begin
                    bcd_out   <= r_work[19:8];
                    bcd_ch    <= r_cur_ch;
                    ovf       <= r_clamp;
                    bcd_valid <= 1'b1;
                    r_state   <= C_IDLE;
                end
                default: r_state <= C_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_convert_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_convert_scheduler
// Purpose  : Self-checking bench: vector table, scoreboard, arbitration cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_convert_scheduler;

    localparam int N_CH = 3;

    logic              clk;
    logic              rst;
    logic [N_CH-1:0]   req;
    logic [8*N_CH-1:0] bin_flat;
    logic [N_CH-1:0]   ack;
    logic              busy;
    logic [11:0]       bcd_out;
    logic [1:0]        bcd_ch;
    logic              bcd_valid;
    logic              ovf;

    bcd_convert_scheduler #(.N_CH(N_CH)) dut (
        .clk(clk), .rst(rst), .req(req), .bin_flat(bin_flat), .ack(ack),
        .busy(busy), .bcd_out(bcd_out), .bcd_ch(bcd_ch),
        .bcd_valid(bcd_valid), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int ch; int op; logic [11:0] bcd; } vec_t;
    typedef struct { int ch; logic [11:0] bcd; logic ovf; } exp_t;

    int   tests    = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t sb[$];
    logic rst_q;
    logic [11:0] prev_bcd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        tests++;
        if (act !== req_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req_v);
        end
    endtask

    // Independent decimal model (division, not shift-and-add).
    function automatic exp_t model(input int ch, input int op);
        exp_t r;
        int   v;
        v     = op;
        r.ovf = 1'b0;
`ifdef BCD_RANGE_CHECK_EN
        if (v > 99) begin
            v     = 99;
            r.ovf = 1'b1;
        end
`endif
        r.ch  = ch;
        r.bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
        return r;
    endfunction

    function automatic int onehot_idx(input logic [N_CH-1:0] g);
        int r;
        r = 0;
        for (int k = 0; k < N_CH; k++) if (g[k]) r = k;
        return r;
    endfunction

    always @(posedge clk) begin
        cyc++;
        rst_q <= rst;
    end

    // Output monitor: scoreboard pop, ack shape, bcd_out stability.
    always @(negedge clk) begin
        if (rst_q === 1'b0) begin
            if (bcd_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result_bcd", bcd_out, e.bcd);
                    check("result_ch", bcd_ch, e.ch);
                    check("result_ovf", ovf, e.ovf);
                end
            end else if (bcd_out !== prev_bcd) begin
                check("bcd_out_stable", bcd_out, prev_bcd);
            end
            if (ack != 0) check("ack_onehot", $onehot(ack), 1);
        end
        prev_bcd = bcd_out;
    end

    task automatic do_reset();
        req = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_ack(output logic [N_CH-1:0] g, output int at);
        g  = '0;
        at = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ack != 0) begin
                g  = ack;
                at = cyc;
                break;
            end
        end
        if (g == 0) check("ack_timeout", 0, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        vec_t        vecs[8];
        logic [N_CH-1:0] g;
        int          at, prev_at, lat, idx;
        bit          seen_valid;
        exp_t        e;

        vecs[0] = '{0, 255, 12'h255};
        vecs[1] = '{0,   0, 12'h000};
        vecs[2] = '{0,  59, 12'h059};
        vecs[3] = '{1,  99, 12'h099};
        vecs[4] = '{2, 100, 12'h100};
        vecs[5] = '{1, 128, 12'h128};
        vecs[6] = '{2,   7, 12'h007};
        vecs[7] = '{2, 150, 12'h150};

        req      = '0;
        bin_flat = '0;
        rst      = 1'b1;
        do_reset();

        check("rst_busy", busy, 0);
        check("rst_ack", ack, 0);
        check("rst_bcd_out", bcd_out, 12'h000);
        check("rst_bcd_ch", bcd_ch, 0);
        check("rst_valid", bcd_valid, 0);
        check("rst_ovf", ovf, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_ack_busy", {ack, busy}, 0);
        end

        // Single-requester table: grant, latency and result.
        for (int i = 0; i < 8; i++) begin
            bin_flat = '0;
            bin_flat[8*vecs[i].ch +: 8] = 8'(vecs[i].op);
            req = '0;
            req[vecs[i].ch] = 1'b1;
            wait_ack(g, at);
            req = '0;
            check("vec_ack", g, 3'b001 << vecs[i].ch);
            if (g != 0) begin
                e.ch  = vecs[i].ch;
                e.bcd = vecs[i].bcd;
                e.ovf = 1'b0;
`ifdef BCD_RANGE_CHECK_EN
                if (vecs[i].op > 99) begin
                    e.bcd = 12'h099;
                    e.ovf = 1'b1;
                end
`endif
                sb.push_back(e);
                lat = 0;
                while (!bcd_valid && lat < 30) begin
                    @(negedge clk);
                    lat++;
                end
                check("vec_latency", lat, 9);
            end
        end
        drain();

        // All three requesting at once: 0, 1, 2 spaced by 10 cycles.
        do_reset();
        bin_flat = {8'd45, 8'd30, 8'd7};
        req      = 3'b111;
        prev_at  = 0;
        for (int k = 0; k < 3; k++) begin
            wait_ack(g, at);
            check("rr3_grant", g, 3'b001 << k);
            if (k > 0) check("rr3_spacing", at - prev_at, 10);
            if (g != 0) begin
                idx = onehot_idx(g);
                sb.push_back(model(idx, int'(bin_flat[8*idx +: 8])));
            end
            req     = req & ~g;
            prev_at = at;
        end
        req = '0;
        drain();

        // ch0 and ch2 held: must alternate.
        do_reset();
        bin_flat = {8'd22, 8'd0, 8'd11};
        req      = 3'b101;
        for (int k = 0; k < 4; k++) begin
            wait_ack(g, at);
            check("alt_grant", g, (k % 2 == 0) ? 3'b001 : 3'b100);
            if (g != 0) begin
                idx = onehot_idx(g);
                sb.push_back(model(idx, int'(bin_flat[8*idx +: 8])));
            end
        end
        req = '0;
        drain();

        // Abort a ch1 conversion at E4; pointer must return to ch0-first.
        bin_flat = {8'd0, 8'd200, 8'd0};
        req      = 3'b010;
        wait_ack(g, at);
        req = '0;
        check("abort_grant", g, 3'b010);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_bcd_out", bcd_out, 12'h000);
        check("abort_valid", bcd_valid, 0);
        rst = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bcd_valid) seen_valid = 1'b1;
        end
        check("abort_no_valid", seen_valid, 0);
        bin_flat = {8'd44, 8'd33, 8'd0};
        req      = 3'b110;
        wait_ack(g, at);
        req = '0;
        check("post_rst_grant", g, 3'b010);
        if (g != 0) sb.push_back(model(onehot_idx(g), int'(bin_flat[8*onehot_idx(g) +: 8])));
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
